// File: rtl/sudoku_grid_checker.sv
// Scans an NxN sudoku board (N = BOX*BOX) row by row from a read-only RAM port
// and reports per-row/column/box error masks, an empty-cell flag and a win flag.
module sudoku_grid_checker #(
    parameter int BOX  = 2,
    parameter int CW   = 4,
    parameter int AW   = 2,
    parameter int AUTO = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    output logic [AW-1:0]            RamAddr,
    input  logic [BOX*BOX*CW-1:0]    RamDat,
    output logic                     busy,
    output logic                     done,
    output logic                     gameComplete,
    output logic                     emptyFound,
    output logic [BOX*BOX-1:0]       rowErr,
    output logic [BOX*BOX-1:0]       colErr,
    output logic [BOX*BOX-1:0]       boxErr
);
    localparam int N = BOX * BOX;
    localparam logic [CW:0] NV = (CW + 1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_EVAL} state_t;

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [N-1:0][N-1:0]   r_col_seen;
    logic [N-1:0][N-1:0]   r_box_seen;
    logic [N-1:0]          r_row_pend, r_col_pend, r_box_pend;
    logic                  r_empty_pend;
    logic                  r_busy, r_done, r_game, r_empty;
    logic [N-1:0]          r_row_err, r_col_err, r_box_err;

    logic                  w_cap;
    int                    w_row;
    logic [N-1:0][N-1:0]   w_col_next, w_box_next;
    logic [N-1:0]          w_row_set, w_col_set, w_box_set;
    logic                  w_empty;

    // The whole row word is checked in one cycle; cells of the same row that share
    // a box are chained through w_box_next so in-word duplicates are caught.
    always_comb begin : comb_scan
        logic [N-1:0]  row_acc;
        logic [N-1:0]  oh;
        logic [CW-1:0] v;
        logic          row_bad;
        int            b;
        w_cap      = (r_state == S_READ && r_addr != '0) || r_state == S_DRAIN;
        w_row      = (r_state == S_DRAIN) ? N - 1 : int'(r_addr) - 1;
        w_col_next = r_col_seen;
        w_box_next = r_box_seen;
        w_row_set  = '0;
        w_col_set  = '0;
        w_box_set  = '0;
        w_empty    = 1'b0;
        row_acc    = '0;
        row_bad    = 1'b0;
        oh         = '0;
        v          = '0;
        b          = 0;
        for (int c = 0; c < N; c++) begin
            v  = RamDat[c*CW +: CW];
            b  = (w_row / BOX) * BOX + c / BOX;
            oh = N'(1) << (v - CW'(1));
            if (v == '0) begin
                w_empty = 1'b1;
            end else if ({1'b0, v} > NV) begin
                row_bad      = 1'b1;
                w_col_set[c] = 1'b1;
                for (int bi = 0; bi < N; bi++)
                    if (bi == b) w_box_set[bi] = 1'b1;
            end else begin
                if ((row_acc & oh) != '0) row_bad = 1'b1;
                row_acc = row_acc | oh;
                if ((r_col_seen[c] & oh) != '0) w_col_set[c] = 1'b1;
                w_col_next[c] = r_col_seen[c] | oh;
                for (int bi = 0; bi < N; bi++) begin
                    if (bi == b) begin
                        if ((w_box_next[bi] & oh) != '0) w_box_set[bi] = 1'b1;
                        w_box_next[bi] = w_box_next[bi] | oh;
                    end
                end
            end
        end
        for (int ri = 0; ri < N; ri++)
            w_row_set[ri] = row_bad && (ri == w_row);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_col_seen   <= '0;
            r_box_seen   <= '0;
            r_row_pend   <= '0;
            r_col_pend   <= '0;
            r_box_pend   <= '0;
            r_empty_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_game       <= 1'b0;
            r_empty      <= 1'b0;
            r_row_err    <= '0;
            r_col_err    <= '0;
            r_box_err    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_cap) begin
                r_row_pend   <= r_row_pend | w_row_set;
                r_col_pend   <= r_col_pend | w_col_set;
                r_box_pend   <= r_box_pend | w_box_set;
                r_empty_pend <= r_empty_pend | w_empty;
                r_col_seen   <= w_col_next;
                r_box_seen   <= w_box_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (AUTO != 0 || start) begin
                        r_state      <= S_READ;
                        r_addr       <= '0;
                        r_col_seen   <= '0;
                        r_box_seen   <= '0;
                        r_row_pend   <= '0;
                        r_col_pend   <= '0;
                        r_box_pend   <= '0;
                        r_empty_pend <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_READ: begin
                    if (r_addr == AW'(N - 1)) r_state <= S_DRAIN;
                    else                      r_addr  <= r_addr + AW'(1);
                end
                S_DRAIN: r_state <= S_EVAL;
                S_EVAL: begin
                    r_row_err <= r_row_pend;
                    r_col_err <= r_col_pend;
                    r_box_err <= r_box_pend;
                    r_empty   <= r_empty_pend;
                    r_game    <= !r_empty_pend && r_row_pend == '0 &&
                                 r_col_pend == '0 && r_box_pend == '0;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RamAddr      = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign gameComplete = r_game;
    assign emptyFound   = r_empty;
    assign rowErr       = r_row_err;
    assign colErr       = r_col_err;
    assign boxErr       = r_box_err;
endmodule
